// File: rtl/ib_lut_sram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ib_lut_sram_loader
//  Brief    : Streams LUT entries into an IB-LUT SRAM (load) or reads them
//             back and compares against a reference stream (verify).
//  Revision : 1.0 - initial release
// ============================================================================
module ib_lut_sram_loader #(
    parameter int ADDR_BITWIDTH = 6,
    parameter int PAGE_SIZE     = 4,
    parameter int PAGE_NUM      = 64,
    parameter int ASYNC_RD      = 1
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     start_load_i,
    input  logic                     start_verify_i,
    input  logic                     abort_i,
    input  logic                     in_valid_i,
    input  logic [PAGE_SIZE-1:0]     in_data_i,
    output logic                     in_ready_o,
    output logic [ADDR_BITWIDTH-1:0] sram_addr_o,
    output logic [PAGE_SIZE-1:0]     sram_wdata_o,
    output logic                     sram_wen_o,
    input  logic [PAGE_SIZE-1:0]     sram_rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDR_BITWIDTH:0]   err_cnt_o,
    output logic [ADDR_BITWIDTH-1:0] first_err_addr_o
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_LOAD    = 3'd1;
    localparam logic [2:0] c_S_V_ISSUE = 3'd2;
    localparam logic [2:0] c_S_V_CMP   = 3'd3;
    localparam logic [2:0] c_S_DONE    = 3'd4;

    localparam logic [ADDR_BITWIDTH-1:0] c_LAST_ADDR = ADDR_BITWIDTH'(PAGE_NUM - 1);
    localparam logic [ADDR_BITWIDTH:0]   c_CNT_MAX   = (ADDR_BITWIDTH + 1)'(PAGE_NUM);

    logic [2:0]               r_state;
    logic [2:0]               w_next_state;
    logic [2:0]               w_verify_state;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic                     r_err;
    logic [ADDR_BITWIDTH:0]   r_err_cnt;
    logic [ADDR_BITWIDTH-1:0] r_first_err_addr;

    logic w_idle;
    logic w_abort;
    logic w_accept;
    logic w_hs;
    logic w_last;
    logic w_start_load;
    logic w_start_verify;
    logic w_mismatch;

    // Registered-read SRAMs need an address-only cycle before each compare.
    generate
        if (ASYNC_RD != 0) begin : g_async_rd
            assign w_verify_state = c_S_V_CMP;
        end else begin : g_sync_rd
            assign w_verify_state = c_S_V_ISSUE;
        end
    endgenerate

    assign w_idle         = (r_state == c_S_IDLE);
    assign w_abort        = abort_i && !w_idle;
    assign w_accept       = ((r_state == c_S_LOAD) || (r_state == c_S_V_CMP)) && !abort_i;
    assign w_hs           = in_valid_i && w_accept;
    assign w_last         = (r_addr == c_LAST_ADDR);
    assign w_start_load   = w_idle && start_load_i;
    assign w_start_verify = w_idle && !start_load_i && start_verify_i;
    assign w_mismatch     = (sram_rdata_i != in_data_i);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start_load_i) begin
                        w_next_state = c_S_LOAD;
                    end else if (start_verify_i) begin
                        w_next_state = w_verify_state;
                    end
                end
                c_S_LOAD: begin
                    if (w_hs && w_last) begin
                        w_next_state = c_S_DONE;
                    end
                end
                c_S_V_ISSUE: w_next_state = c_S_V_CMP;
                c_S_V_CMP: begin
                    if (w_hs) begin
                        w_next_state = w_last ? c_S_DONE : w_verify_state;
                    end
                end
                c_S_DONE: w_next_state = c_S_IDLE;
                default:  w_next_state = c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o   = w_accept;
        sram_wen_o   = 1'b1;
        sram_wdata_o = '0;
        done_o       = 1'b0;
        busy_o       = !w_idle;
        case (r_state)
            c_S_LOAD: begin
                sram_wdata_o = in_data_i;
                sram_wen_o   = !w_hs;
            end
            c_S_DONE: done_o = !abort_i;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_addr           <= '0;
            r_err            <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else begin
            if (w_start_load || w_start_verify || w_abort || (r_state == c_S_DONE)) begin
                r_addr <= '0;
            end else if (w_hs) begin
                r_addr <= w_last ? '0 : r_addr + 1'b1;
            end

            // First-error address latches only on the transition into error.
            if (w_start_verify) begin
                r_err            <= 1'b0;
                r_err_cnt        <= '0;
                r_first_err_addr <= '0;
            end else if ((r_state == c_S_V_CMP) && w_hs && w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != c_CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_err) begin
                    r_first_err_addr <= r_addr;
                end
            end
        end
    end

    assign sram_addr_o      = r_addr;
    assign err_o            = r_err;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ib_lut_sram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ib_lut_sram_loader
//  Brief    : Bench for ib_lut_sram_loader with async-read and registered-read
//             SRAM models (instance 0 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ib_lut_sram_loader;

    typedef struct packed {
        logic [5:0] a;
        logic [3:0] w;
    } wr_t;

    typedef struct {
        int d; bit verify; bit gaps; int seed; int c1; int c2;
        int e_err; int e_cnt; int e_first; int e_cyc;
    } vec_t;

    logic r_clk;
    logic r_rstn;
    logic r_start_load [2];
    logic r_start_verify [2];
    logic r_abort [2];
    logic r_in_valid [2];
    logic [3:0] r_in_data [2];
    logic w_in_ready [2];
    logic [5:0] w_addr [2];
    logic [3:0] w_wdata [2];
    logic w_wen [2];
    logic w_busy [2];
    logic w_done [2];
    logic w_err [2];
    logic [6:0] w_err_cnt [2];
    logic [5:0] w_first [2];
    logic [3:0] w_rdata0;
    logic [3:0] r_rdata1;
    logic [3:0] r_mem [2][64];

    wr_t exp_q0[$];
    wr_t exp_q1[$];
    int  checks = 0;
    int  errors = 0;

    ib_lut_sram_loader #(.ADDR_BITWIDTH(6), .PAGE_SIZE(4), .PAGE_NUM(64), .ASYNC_RD(1)) u_dut_async (
        .sys_clk(r_clk), .rstn(r_rstn),
        .start_load_i(r_start_load[0]), .start_verify_i(r_start_verify[0]), .abort_i(r_abort[0]),
        .in_valid_i(r_in_valid[0]), .in_data_i(r_in_data[0]), .in_ready_o(w_in_ready[0]),
        .sram_addr_o(w_addr[0]), .sram_wdata_o(w_wdata[0]), .sram_wen_o(w_wen[0]),
        .sram_rdata_i(w_rdata0), .busy_o(w_busy[0]), .done_o(w_done[0]), .err_o(w_err[0]),
        .err_cnt_o(w_err_cnt[0]), .first_err_addr_o(w_first[0])
    );

    ib_lut_sram_loader #(.ADDR_BITWIDTH(6), .PAGE_SIZE(4), .PAGE_NUM(64), .ASYNC_RD(0)) u_dut_sync (
        .sys_clk(r_clk), .rstn(r_rstn),
        .start_load_i(r_start_load[1]), .start_verify_i(r_start_verify[1]), .abort_i(r_abort[1]),
        .in_valid_i(r_in_valid[1]), .in_data_i(r_in_data[1]), .in_ready_o(w_in_ready[1]),
        .sram_addr_o(w_addr[1]), .sram_wdata_o(w_wdata[1]), .sram_wen_o(w_wen[1]),
        .sram_rdata_i(r_rdata1), .busy_o(w_busy[1]), .done_o(w_done[1]), .err_o(w_err[1]),
        .err_cnt_o(w_err_cnt[1]), .first_err_addr_o(w_first[1])
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // SRAM models: instance 0 reads combinationally, instance 1 one cycle late.
    always @(posedge r_clk) begin
        if (!w_wen[0]) r_mem[0][w_addr[0]] <= w_wdata[0];
        if (!w_wen[1]) r_mem[1][w_addr[1]] <= w_wdata[1];
        r_rdata1 <= r_mem[1][w_addr[1]];
    end
    assign w_rdata0 = r_mem[0][w_addr[0]];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input int a, input logic [3:0] w);
        wr_t e;
        e.a = 6'(a);
        e.w = w;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic mon_write(input int d, input logic [5:0] a, input logic [3:0] w);
        wr_t e;
        int  n;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL unexpected_write dut%0d: addr %0d data %0d, expected no write", d, a, w);
        end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (e.a != a || e.w != w) begin
                errors++;
                $display("FAIL write dut%0d: addr %0d data %0d, expected addr %0d data %0d",
                         d, a, w, e.a, e.w);
            end
        end
    endtask

    // Write monitor: samples mid-cycle, before the capturing edge.
    always @(negedge r_clk) begin
        #3;
        for (int d = 0; d < 2; d++)
            if (r_rstn && !w_wen[d]) mon_write(d, w_addr[d], w_wdata[d]);
    end

    function automatic logic [3:0] pat(input int k, input int seed);
        return 4'(k ^ seed);
    endfunction

    task automatic run_pass(input int d, input bit verify, input bit gaps, input bit both,
                            input int seed, input int c1, input int c2,
                            output int cycles, output int ndone);
        int k;
        bit v;
        logic [3:0] dat;
        k = 0; cycles = 0; ndone = 0;
        @(negedge r_clk);
        if (verify) r_start_verify[d] = 1'b1;
        else        r_start_load[d]   = 1'b1;
        if (both)   r_start_verify[d] = 1'b1;
        r_in_valid[d] = 1'b0;
        for (int n = 0; n < 400 && ndone == 0; n++) begin
            @(negedge r_clk);
            r_start_load[d]   = 1'b0;
            r_start_verify[d] = 1'b0;
            cycles++;
            if (w_done[d]) begin
                ndone++;
                r_in_valid[d] = 1'b0;
                check($sformatf("done_after_last_dut%0d", d), k, 64);
            end else begin
                v   = (k < 64) && (!gaps || $urandom_range(0, 2) != 0);
                dat = pat(k, seed);
                if (verify && (k == c1 || k == c2)) dat = ~dat;
                r_in_valid[d] = v;
                r_in_data[d]  = dat;
                if (gaps && k == 30) r_start_verify[d] = 1'b1;
                if (v && w_in_ready[d]) begin
                    if (!verify) push_exp(d, k, dat);
                    k++;
                end
            end
        end
        r_in_valid[d] = 1'b0;
        repeat (3) begin
            @(negedge r_clk);
            if (w_done[d]) ndone++;
        end
    endtask

    initial begin
        vec_t vt[7];
        int   cyc, nd, k;

        vt[0] = '{0, 0, 0, 0, -1, -1, 0, 0, 0, 65};
        vt[1] = '{0, 1, 0, 0, -1, -1, 0, 0, 0, 65};
        vt[2] = '{1, 0, 0, 0, -1, -1, 0, 0, 0, 65};
        vt[3] = '{1, 1, 0, 0, -1, -1, 0, 0, 0, 129};
        vt[4] = '{0, 1, 0, 0, 5, 40, 1, 2, 5, 65};
        vt[5] = '{0, 0, 1, 5, -1, -1, 1, 2, 5, -1};
        vt[6] = '{0, 1, 0, 5, -1, -1, 0, 0, 0, 65};

        r_rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r_start_load[d] = 0; r_start_verify[d] = 0; r_abort[d] = 0;
            r_in_valid[d] = 0; r_in_data[d] = '0;
        end
        repeat (3) @(negedge r_clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready_dut%0d", d), int'(w_in_ready[d]), 0);
            check($sformatf("rst_wen_dut%0d", d), int'(w_wen[d]), 1);
            check($sformatf("rst_busy_dut%0d", d), int'(w_busy[d]), 0);
            check($sformatf("rst_done_dut%0d", d), int'(w_done[d]), 0);
            check($sformatf("rst_err_dut%0d", d), int'(w_err[d]), 0);
            check($sformatf("rst_addr_dut%0d", d), int'(w_addr[d]), 0);
        end
        r_rstn = 1'b1;
        @(negedge r_clk);

        for (int i = 0; i < 7; i++) begin
            run_pass(vt[i].d, vt[i].verify, vt[i].gaps, 1'b0, vt[i].seed, vt[i].c1, vt[i].c2, cyc, nd);
            check($sformatf("v%0d_done_count", i), nd, 1);
            if (vt[i].e_cyc >= 0) check($sformatf("v%0d_cycles", i), cyc, vt[i].e_cyc);
            check($sformatf("v%0d_err", i), int'(w_err[vt[i].d]), vt[i].e_err);
            check($sformatf("v%0d_err_cnt", i), int'(w_err_cnt[vt[i].d]), vt[i].e_cnt);
            check($sformatf("v%0d_first_err", i), int'(w_first[vt[i].d]), vt[i].e_first);
            check($sformatf("v%0d_pending_writes", i),
                  (vt[i].d == 0) ? exp_q0.size() : exp_q1.size(), 0);
        end
        k = 0;
        for (int a = 0; a < 64; a++) if (r_mem[0][a] !== pat(a, 5)) k++;
        check("gap_load_mem_bad_words", k, 0);

        // Abort a load after 20 accepted beats.
        @(negedge r_clk);
        r_start_load[0] = 1'b1;
        k = 0;
        for (int n = 0; n < 100 && k < 20; n++) begin
            @(negedge r_clk);
            r_start_load[0] = 1'b0;
            r_in_valid[0]   = 1'b1;
            r_in_data[0]    = pat(k, 9);
            if (w_in_ready[0]) begin
                push_exp(0, k, pat(k, 9));
                k++;
            end
        end
        @(negedge r_clk);
        check("abort_addr", int'(w_addr[0]), 20);
        r_abort[0]    = 1'b1;
        r_in_valid[0] = 1'b1;
        r_in_data[0]  = pat(20, 9);
        #1;
        check("abort_wen", int'(w_wen[0]), 1);
        check("abort_ready", int'(w_in_ready[0]), 0);
        @(negedge r_clk);
        r_abort[0]    = 1'b0;
        r_in_valid[0] = 1'b0;
        check("abort_busy", int'(w_busy[0]), 0);
        nd = 0;
        repeat (3) begin
            if (w_done[0]) nd++;
            @(negedge r_clk);
        end
        check("abort_no_done", nd, 0);
        run_pass(0, 1'b0, 1'b0, 1'b0, 9, -1, -1, cyc, nd);
        check("reload_cycles", cyc, 65);
        check("reload_pending_writes", exp_q0.size(), 0);

        // Asynchronous reset in the middle of a verify that already saw an error.
        @(negedge r_clk);
        r_start_verify[0] = 1'b1;
        k = 0;
        for (int n = 0; n < 100 && k < 10; n++) begin
            @(negedge r_clk);
            r_start_verify[0] = 1'b0;
            r_in_valid[0]     = 1'b1;
            r_in_data[0]      = (k == 2) ? ~pat(k, 9) : pat(k, 9);
            if (w_in_ready[0]) k++;
        end
        @(negedge r_clk);
        r_in_valid[0] = 1'b0;
        check("preflush_err", int'(w_err[0]), 1);
        check("preflush_addr", int'(w_addr[0]), 10);
        #2 r_rstn = 1'b0;
        #1;
        check("arst_err", int'(w_err[0]), 0);
        check("arst_err_cnt", int'(w_err_cnt[0]), 0);
        check("arst_first", int'(w_first[0]), 0);
        check("arst_addr", int'(w_addr[0]), 0);
        check("arst_busy", int'(w_busy[0]), 0);
        check("arst_ready", int'(w_in_ready[0]), 0);
        check("arst_wen", int'(w_wen[0]), 1);
        check("arst_wdata", int'(w_wdata[0]), 0);
        @(negedge r_clk);
        r_rstn = 1'b1;

        // Both starts together: load must win, then verify the result.
        run_pass(0, 1'b0, 1'b0, 1'b1, 3, -1, -1, cyc, nd);
        check("both_start_cycles", cyc, 65);
        check("both_start_done", nd, 1);
        check("both_start_pending", exp_q0.size(), 0);
        run_pass(0, 1'b1, 1'b0, 1'b0, 3, -1, -1, cyc, nd);
        check("both_start_verify_err_cnt", int'(w_err_cnt[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
